linear_feedback_shift_register: RTL and testbench

Seedable Fibonacci linear feedback shift register producing a pseudo-random sequence, one new state per clock. Synchronous reset loads the state from `data_in`, so reset doubles as a seed load. The default 3-bit configuration uses polynomial x^3+x^2+1 and cycles through all 7 non-zero states. Used as a lightweight test-pattern and pseudo-random source inside the sequential-circuits library.

---
 rtl/lfsr_pkg.sv | 29 ++
 rtl/lfsr_next_state.sv | 29 ++
 rtl/linear_feedback_shift_register.sv | 42 ++++
 tb/tb_linear_feedback_shift_register.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared constants for the Fibonacci LFSR: maximal-length tap masks,
// a wide state type, and the all-zero / lockup-replacement values.
package lfsr_pkg;

    localparam int MAX_WIDTH = 32;

    typedef logic [MAX_WIDTH-1:0] state_t;

    // Bit i set means sreg[i] feeds the XOR; masks give maximal period 2^W-1.
    localparam logic [1:0]  TAPS_2  = 2'b11;
    localparam logic [2:0]  TAPS_3  = 3'b110;
    localparam logic [3:0]  TAPS_4  = 4'b1100;
    localparam logic [4:0]  TAPS_5  = 5'b10100;
    localparam logic [5:0]  TAPS_6  = 6'b110000;
    localparam logic [6:0]  TAPS_7  = 7'b1100000;
    localparam logic [7:0]  TAPS_8  = 8'b10111000;
    localparam logic [8:0]  TAPS_9  = 9'b100010000;
    localparam logic [9:0]  TAPS_10 = 10'b1001000000;
    localparam logic [10:0] TAPS_11 = 11'b10100000000;
    localparam logic [11:0] TAPS_12 = 12'b111000001000;
    localparam logic [12:0] TAPS_13 = 13'b1110010000000;
    localparam logic [13:0] TAPS_14 = 14'b11100000000010;
    localparam logic [14:0] TAPS_15 = 15'b110000000000000;
    localparam logic [15:0] TAPS_16 = 16'b1101000000001000;

    localparam state_t ALL_ZERO    = '0;
    localparam state_t LOCKUP_FILL = state_t'(1);

endpackage

// File: rtl/lfsr_next_state.sv
// Combinational next-state and seed conditioning for the LFSR.
// With LFSR_LOCKUP_GUARD_EN defined, an all-zero result is replaced by 1.
import lfsr_pkg::*;

module lfsr_next_state #(
    parameter int              WIDTH = 3,
    parameter logic [WIDTH-1:0] TAPS = 3'b110
) (
    input  logic [WIDTH-1:0] state,
    input  logic [WIDTH-1:0] seed,
    output logic [WIDTH-1:0] next_state,
    output logic [WIDTH-1:0] seed_load
);

    logic             fb;
    logic [WIDTH-1:0] shifted;

    assign fb      = ^(state & TAPS);
    assign shifted = {state[WIDTH-2:0], fb};

`ifdef LFSR_LOCKUP_GUARD_EN
    assign next_state = (shifted == ALL_ZERO[WIDTH-1:0]) ? LOCKUP_FILL[WIDTH-1:0] : shifted;
    assign seed_load  = (seed == ALL_ZERO[WIDTH-1:0])    ? LOCKUP_FILL[WIDTH-1:0] : seed;
`else
    assign next_state = shifted;
    assign seed_load  = seed;
`endif

endmodule

// File: rtl/linear_feedback_shift_register.sv
// Seedable Fibonacci LFSR; synchronous reset loads the seed from data_in.
// Optional build macro LFSR_LOCKUP_GUARD_EN prevents the all-zero lockup state.
import lfsr_pkg::*;

module linear_feedback_shift_register #(
    parameter int               WIDTH = 3,
    parameter logic [WIDTH-1:0] TAPS  = 3'b110
) (
    input  logic [WIDTH-1:0] data_in,
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] sreg
);

    generate
        if (WIDTH < 2 || WIDTH > MAX_WIDTH || TAPS == '0) begin : g_param_check
            $error("linear_feedback_shift_register: WIDTH must be 2..32 and TAPS non-zero");
        end
    endgenerate

    logic [WIDTH-1:0] next_state;
    logic [WIDTH-1:0] seed_load;

    lfsr_next_state #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_next (
        .state      (sreg),
        .seed       (data_in),
        .next_state (next_state),
        .seed_load  (seed_load)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            sreg <= seed_load;
        end else begin
            sreg <= next_state;
        end
    end

endmodule

// File: tb/tb_linear_feedback_shift_register.sv
// Directed scoreboard bench for linear_feedback_shift_register (3-bit default
// instance plus a 4-bit instance); honours LFSR_LOCKUP_GUARD_EN if defined.
module tb_linear_feedback_shift_register;

    logic       clk = 1'b0;
    logic       rst3 = 1'b1;
    logic [2:0] din3 = 3'b000;
    logic [2:0] sreg3;
    logic       rst4 = 1'b1;
    logic [3:0] din4 = 4'b0000;
    logic [3:0] sreg4;

    int vectors = 0;
    int miscompares = 0;

    logic [2:0] exp3_q[$];
    logic [3:0] exp4_q[$];
    string      tag_q[$];

    always #5 clk = ~clk;

    linear_feedback_shift_register dut3 (
        .data_in (din3),
        .clk     (clk),
        .rst     (rst3),
        .sreg    (sreg3)
    );

    linear_feedback_shift_register #(.WIDTH(4), .TAPS(4'b1100)) dut4 (
        .data_in (din4),
        .clk     (clk),
        .rst     (rst4),
        .sreg    (sreg4)
    );

    // Drive away from the active edge, push the expectation, then check after the edge.
    task automatic step3(input logic r, input logic [2:0] d, input logic [2:0] e, input string tag);
        logic [2:0] ex;
        string      t;
        @(negedge clk);
        rst3 = r;
        din3 = d;
        exp3_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        ex = exp3_q.pop_front();
        t  = tag_q.pop_front();
        vectors++;
        assert (sreg3 === ex) else begin
            miscompares++;
            $error("FAIL %s: sreg=%b expected %b", t, sreg3, ex);
        end
    endtask

    task automatic step4(input logic r, input logic [3:0] d, input logic [3:0] e, input string tag);
        logic [3:0] ex;
        string      t;
        @(negedge clk);
        rst4 = r;
        din4 = d;
        exp4_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        ex = exp4_q.pop_front();
        t  = tag_q.pop_front();
        vectors++;
        assert (sreg4 === ex) else begin
            miscompares++;
            $error("FAIL %s: sreg4=%b expected %b", t, sreg4, ex);
        end
    endtask

    // Reference for x^4+x^3+1: new bit0 = bit3 ^ bit2.
    function automatic logic [3:0] ref4(input logic [3:0] s);
        return {s[2:0], s[3] ^ s[2]};
    endfunction

    initial begin
        logic [2:0] seq7[7];
        logic [3:0] m4;
        logic [15:0] seen;
        int          distinct;

        seq7[0] = 3'b101; seq7[1] = 3'b011; seq7[2] = 3'b111; seq7[3] = 3'b110;
        seq7[4] = 3'b100; seq7[5] = 3'b001; seq7[6] = 3'b010;

        // Seed load held for 4 edges, then seed change while still in reset.
        for (int i = 0; i < 4; i++) step3(1'b1, 3'b010, 3'b010, "seed_hold");
        step3(1'b1, 3'b101, 3'b101, "seed_change");
        step3(1'b1, 3'b010, 3'b010, "seed_reload");

        // Full sequence over three periods.
        for (int i = 0; i < 21; i++) step3(1'b0, 3'b000, seq7[i % 7], "period7");

        // Reset mid-run.
        step3(1'b1, 3'b010, 3'b010, "mid_seed");
        step3(1'b0, 3'b000, 3'b101, "mid_shift1");
        step3(1'b0, 3'b000, 3'b011, "mid_shift2");
        step3(1'b0, 3'b000, 3'b111, "mid_shift3");
        step3(1'b1, 3'b100, 3'b100, "mid_reload");
        step3(1'b0, 3'b000, 3'b001, "mid_after1");
        step3(1'b0, 3'b000, 3'b010, "mid_after2");
        step3(1'b0, 3'b000, 3'b101, "mid_after3");

        // Zero seed.
`ifdef LFSR_LOCKUP_GUARD_EN
        step3(1'b1, 3'b000, 3'b001, "zero_seed_guard");
        step3(1'b0, 3'b000, 3'b010, "zero_guard1");
        step3(1'b0, 3'b000, 3'b101, "zero_guard2");
        step3(1'b0, 3'b000, 3'b011, "zero_guard3");
`else
        step3(1'b1, 3'b000, 3'b000, "zero_seed");
        for (int i = 0; i < 10; i++) step3(1'b0, 3'b000, 3'b000, "zero_lock");
`endif

        // Width 4: visit all 15 non-zero states and return to the seed.
        step4(1'b1, 4'b0001, 4'b0001, "w4_seed");
        m4 = 4'b0001;
        seen = '0;
        for (int i = 0; i < 15; i++) begin
            m4 = ref4(m4);
            step4(1'b0, 4'b0000, m4, "w4_seq");
            seen[sreg4] = 1'b1;
        end
        distinct = 0;
        for (int i = 1; i < 16; i++) if (seen[i]) distinct++;
        vectors++;
        assert (distinct === 15 && seen[0] === 1'b0) else begin
            miscompares++;
            $error("FAIL w4_coverage: distinct=%0d zero_seen=%b expected 15 and 0", distinct, seen[0]);
        end
        vectors++;
        assert (sreg4 === 4'b0001) else begin
            miscompares++;
            $error("FAIL w4_return: sreg4=%b expected 0001", sreg4);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete within 100000 time units");
        $fatal(1, "timeout");
    end

endmodule
